tdoa_capture_n: RTL and testbench

Parametrised time-difference-of-arrival capture engine for an N-microphone array. It monitors N signed PCM streams and timestamps each channel's first above-threshold sample against a shared sample counter. Once every channel has fired, it presents the timestamp set to the CPU-facing register interface and holds it until acknowledged. A window timeout rearms the engine when only some channels fire. It sits between the PCM deserialisers and the CPU bus bridge, replacing the fixed three-channel capture.

---
 rtl/tdoa_capture_n.sv | 208 ++++++++++++++++++++
 tb/tb_tdoa_capture_n.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdoa_capture_n.sv
// N-channel time-difference-of-arrival capture: timestamps each channel's first over-threshold
// sample against a shared counter. Define TDOA_RELATIVE_EN to report times relative to the earliest.
module tdoa_capture_n #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TIME_W = 32,
    parameter int unsigned WINDOW = 4800
) (
    input  logic                       pcm_clk_i,
    input  logic                       reset_i,
    input  logic                       sample_valid_i,
    input  logic [NUM_CH*DATA_W-1:0]   pcm_data_i,
    input  logic [DATA_W-2:0]          threshold_i,
    input  logic                       arm_i,
    input  logic                       ack_i,
    output logic [NUM_CH*TIME_W-1:0]   trigger_time_o,
    output logic                       times_valid_o,
    output logic                       timeout_o,
    output logic                       busy_o
);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StReport} state_e;

    localparam logic [TIME_W-1:0] WindowLimit = TIME_W'(WINDOW);

    state_e                         state_q, state_d;
    logic [TIME_W-1:0]              sample_cnt_q, sample_cnt_d;
    logic [TIME_W-1:0]              window_cnt_q, window_cnt_d;
    logic [NUM_CH-1:0]              flags_q, flags_d;
    logic [NUM_CH-1:0][TIME_W-1:0]  latched_q, latched_d;
    logic [NUM_CH*TIME_W-1:0]       trig_q, trig_d;
    logic                           timeout_q, timeout_d;

    logic [NUM_CH-1:0]              over_thr;
    logic [NUM_CH-1:0]              trip;
    logic [NUM_CH-1:0][TIME_W-1:0]  report_val;
    logic                           all_set;
    logic                           window_open;
    logic                           trip_en;
    logic                           arm_accept;

    // Magnitude in DATA_W+1 bits so the most negative sample does not overflow.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W:0] ext;
        logic [DATA_W:0] mag;
        assign ext         = {pcm_data_i[k*DATA_W+DATA_W-1], pcm_data_i[k*DATA_W +: DATA_W]};
        assign mag         = ext[DATA_W] ? -ext : ext;
        assign over_thr[k] = mag > {2'b00, threshold_i};
    end

    assign all_set     = &flags_q;
    assign window_open = window_cnt_q < WindowLimit;
    assign arm_accept  = (state_q == StIdle) && arm_i;

    always_comb begin
        trip_en = 1'b0;
        if (sample_valid_i) begin
            if (state_q == StArmed) begin
                trip_en = 1'b1;
            end else if (state_q == StCapture && !all_set && window_open) begin
                trip_en = 1'b1;
            end
        end
        trip = over_thr & ~flags_q & {NUM_CH{trip_en}};
    end

`ifdef TDOA_RELATIVE_EN
    // Referenced to the first trip, not min(latched), so counter wrap between trips is harmless.
    logic [TIME_W-1:0] first_ts_q, first_ts_d;

    always_comb begin
        first_ts_d = first_ts_q;
        if (state_q == StArmed && |trip) begin
            first_ts_d = sample_cnt_q;
        end
    end

    always_ff @(posedge pcm_clk_i) begin
        if (reset_i) begin
            first_ts_q <= '0;
        end else begin
            first_ts_q <= first_ts_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            report_val[k] = latched_q[k] - first_ts_q;
        end
    end
`else
    assign report_val = latched_q;
`endif

    // State register.
    always_ff @(posedge pcm_clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; completion takes priority over window expiry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (arm_i) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (|trip) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (all_set) begin
                    state_d = StReport;
                end else if (!window_open) begin
                    state_d = StIdle;
                end
            end
            StReport: begin
                if (ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        times_valid_o = 1'b0;
        busy_o        = 1'b0;
        unique case (state_q)
            StArmed, StCapture: busy_o        = 1'b1;
            StReport:           times_valid_o = 1'b1;
            default: begin
                times_valid_o = 1'b0;
                busy_o        = 1'b0;
            end
        endcase
    end

    assign trigger_time_o = trig_q;
    assign timeout_o      = timeout_q;

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        window_cnt_d = window_cnt_q;
        flags_d      = flags_q;
        latched_d    = latched_q;
        trig_d       = trig_q;
        timeout_d    = timeout_q;

        if (sample_valid_i) begin
            sample_cnt_d = sample_cnt_q + TIME_W'(1);
        end

        if (arm_accept) begin
            flags_d      = '0;
            window_cnt_d = '0;
            timeout_d    = 1'b0;
        end

        flags_d = flags_d | trip;
        for (int k = 0; k < NUM_CH; k++) begin
            if (trip[k]) begin
                latched_d[k] = sample_cnt_q;
            end
        end

        if (state_q == StCapture && !all_set) begin
            if (sample_valid_i && window_open) begin
                window_cnt_d = window_cnt_q + TIME_W'(1);
            end
            if (!window_open) begin
                timeout_d = 1'b1;
            end
        end

        if (state_q == StCapture && all_set) begin
            trig_d = report_val;
        end
    end

    always_ff @(posedge pcm_clk_i) begin
        if (reset_i) begin
            sample_cnt_q <= '0;
            window_cnt_q <= '0;
            flags_q      <= '0;
            latched_q    <= '0;
            trig_q       <= '0;
            timeout_q    <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            window_cnt_q <= window_cnt_d;
            flags_q      <= flags_d;
            latched_q    <= latched_d;
            trig_q       <= trig_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_tdoa_capture_n.sv
// Scoreboard bench for tdoa_capture_n: directed stimulus pushes expected reports/timeouts,
// a monitor pops them on the rising edge of times_valid / timeout.
module tb_tdoa_capture_n;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TIME_W = 10;
    localparam int unsigned WINDOW = 10;

`ifdef TDOA_RELATIVE_EN
    localparam bit Rel = 1'b1;
`else
    localparam bit Rel = 1'b0;
`endif

    typedef struct packed {
        logic        is_to;
        logic [29:0] tt;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      sample_valid = 1'b0;
    logic [NUM_CH*DATA_W-1:0]  pcm_data = '0;
    logic [DATA_W-2:0]         threshold = 15'd1000;
    logic                      arm = 1'b0;
    logic                      ack = 1'b0;
    logic [NUM_CH*TIME_W-1:0]  trigger_time;
    logic                      times_valid;
    logic                      timeout;
    logic                      busy;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [9:0]  cnt = '0;
    logic [29:0] last_tt = '0;
    logic        tv_prev = 1'b0;
    logic        to_prev = 1'b0;

    tdoa_capture_n #(
        .NUM_CH(NUM_CH),
        .DATA_W(DATA_W),
        .TIME_W(TIME_W),
        .WINDOW(WINDOW)
    ) dut (
        .pcm_clk_i      (clk),
        .reset_i        (reset),
        .sample_valid_i (sample_valid),
        .pcm_data_i     (pcm_data),
        .threshold_i    (threshold),
        .arm_i          (arm),
        .ack_i          (ack),
        .trigger_time_o (trigger_time),
        .times_valid_o  (times_valid),
        .timeout_o      (timeout),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk_rep(input logic [9:0] t0, input logic [9:0] t1,
                                    input logic [9:0] t2, input logic [9:0] first);
        exp_t e;
        logic [9:0] r0, r1, r2;
        r0 = t0 - first;
        r1 = t1 - first;
        r2 = t2 - first;
        e.is_to = 1'b0;
        e.tt    = Rel ? {r2, r1, r0} : {t2, t1, t0};
        return e;
    endfunction

    task automatic push_rep(input exp_t e);
        exp_q.push_back(e);
        last_tt = e.tt;
    endtask

    task automatic push_to();
        exp_t e;
        e.is_to = 1'b1;
        e.tt    = '0;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        pcm_data     = {c, b, a};
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        pcm_data     = '0;
        cnt          = cnt + 10'd1;
    endtask

    task automatic zeros(input int n);
        repeat (n) sample(16'd0, 16'd0, 16'd0);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        cnt   = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " trigger_time"}, 32'(trigger_time), 32'd0);
        check({tag, " times_valid"}, 32'(times_valid), 32'd0);
        check({tag, " timeout"}, 32'(timeout), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: pops one expectation per rising edge of times_valid or timeout.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (times_valid && !tv_prev) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL report: unexpected report tt=%0h", trigger_time);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_to || trigger_time !== e.tt) begin
                        n_err++;
                        $display("FAIL report: got tt=%0h, want is_to=%0b tt=%0h",
                                 trigger_time, e.is_to, e.tt);
                    end
                end
            end
            if (timeout && !to_prev) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL timeout: unexpected timeout");
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_to) begin
                        n_err++;
                        $display("FAIL timeout: got timeout, want report tt=%0h", e.tt);
                    end
                end
            end
            tv_prev = times_valid;
            to_prev = timeout;
        end
    end

    initial begin : stim
        logic [9:0] c;
        tick(2);
        reset = 1'b0;
        check_all_zero("reset");

        // Basic staggered capture: 105/110/112.
        zeros(100);
        pulse_arm();
        check("arm busy", 32'(busy), 32'd1);
        zeros(5);
        sample(16'd2000, 16'd0, 16'd0);
        zeros(4);
        sample(16'd0, -16'sd1500, 16'd0);
        zeros(1);
        push_rep(mk_rep(10'd105, 10'd110, 10'd112, 10'd105));
        sample(16'd0, 16'd0, 16'd1200);
        tick(2);
        check("t1 times_valid", 32'(times_valid), 32'd1);
        check("t1 busy", 32'(busy), 32'd0);
        pulse_ack();
        check("t1 ack", 32'(times_valid), 32'd0);
        check("t1 hold", 32'(trigger_time), 32'(last_tt));

        // Simultaneous trips on channels 0 and 2.
        pulse_arm();
        c = cnt;
        sample(16'd2000, 16'd0, 16'd2000);
        push_rep(mk_rep(c, c + 10'd1, c, c));
        sample(16'd0, 16'd2000, 16'd0);
        tick(2);
        check("t2 times_valid", 32'(times_valid), 32'd1);
        pulse_ack();

        // Window timeout: only channels 0 and 1 trip.
        pulse_arm();
        sample(16'd2000, 16'd0, 16'd0);
        zeros(1);
        sample(16'd0, 16'd2000, 16'd0);
        zeros(7);
        check("t3 busy before expiry", 32'(busy), 32'd1);
        push_to();
        zeros(1);
        check("t3 busy at expiry", 32'(busy), 32'd1);
        check("t3 timeout at expiry", 32'(timeout), 32'd0);
        tick(1);
        check("t3 timeout", 32'(timeout), 32'd1);
        check("t3 busy", 32'(busy), 32'd0);
        check("t3 tt unchanged", 32'(trigger_time), 32'(last_tt));
        pulse_arm();
        check("t3 arm clears timeout", 32'(timeout), 32'd0);

        // Last trip on the expiry sample: completion wins.
        c = cnt;
        sample(16'd2000, 16'd0, 16'd0);
        sample(16'd0, 16'd2000, 16'd0);
        zeros(8);
        push_rep(mk_rep(c, c + 10'd1, c + 10'd10, c));
        sample(16'd0, 16'd0, 16'd2000);
        tick(2);
        check("t4 times_valid", 32'(times_valid), 32'd1);
        check("t4 timeout", 32'(timeout), 32'd0);
        pulse_ack();

        // Equal-to-threshold does not trip.
        pulse_arm();
        sample(16'd1000, -16'sd1000, 16'd1000);
        c = cnt;
        sample(16'd1001, 16'd0, 16'd0);
        sample(16'd0, -16'sd1001, 16'd0);
        push_rep(mk_rep(c, c + 10'd1, c + 10'd2, c));
        sample(16'd0, 16'd0, 16'd1001);
        tick(2);
        pulse_ack();

        // Most negative sample against the largest threshold.
        threshold = 15'd32767;
        pulse_arm();
        sample(16'd32767, -16'sd32767, 16'd32767);
        c = cnt;
        sample(16'h8000, 16'd0, 16'd0);
        sample(16'd0, 16'h8000, 16'd0);
        push_rep(mk_rep(c, c + 10'd1, c + 10'd2, c));
        sample(16'd0, 16'd0, 16'h8000);
        tick(2);
        pulse_ack();
        threshold = 15'd1000;

        // Counter wrap between trips.
        while (cnt != 10'd1023) sample(16'd0, 16'd0, 16'd0);
        pulse_arm();
        sample(16'd2000, 16'd0, 16'd0);
        sample(16'd0, 16'd2000, 16'd0);
        push_rep(mk_rep(10'd1023, 10'd0, 10'd1, 10'd1023));
        sample(16'd0, 16'd0, 16'd2000);
        tick(2);
        check("t7 times_valid", 32'(times_valid), 32'd1);
        pulse_ack();

        // Reset mid-capture, then a fresh capture (channel 1 earliest).
        pulse_arm();
        sample(16'd2000, 16'd0, 16'd0);
        do_reset();
        check_all_zero("t8 reset");
        pulse_arm();
        zeros(3);
        sample(16'd0, 16'd2000, 16'd0);
        sample(16'd2000, 16'd0, 16'd0);
        push_rep(mk_rep(10'd4, 10'd3, 10'd5, 10'd3));
        sample(16'd0, 16'd0, 16'd2000);
        tick(2);
        check("t8 times_valid", 32'(times_valid), 32'd1);
        pulse_ack();

        tick(3);
        check("pending expectations", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
